// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ccff_loader_pkg                                                            |
// | Shared states, mode encodings and widths for the config-chain loader.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;

  localparam int MISMATCH_W = 16;

endpackage
`default_nettype wire

// File: rtl/ccff_word_piso.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ccff_word_piso                                                             |
// | Word-wide parallel-in/serial-out register; MSB leaves first.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ccff_word_piso
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_msb
);

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  // A reload wins over a shift so a streamed word replaces the spent one.
  always_comb begin
    word_d = word_q;
    if (i_load) begin
      word_d = i_word;
    end else if (i_shift) begin
      word_d = {word_q[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign o_msb = word_q[WORD_W-1];

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ccff_chain_loader                                                          |
// | Streams host words MSB-first into a config chain; VERIFY re-shifts and     |
// | compares the chain tail against the head.                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  input  logic [WORD_W-1:0]     cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [MISMATCH_W-1:0] mismatch_cnt
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]       wbit_q, wbit_d;
  logic                  shift_en_q, shift_en_d;
  logic                  error_q, error_d;
  logic [MISMATCH_W-1:0] mis_q, mis_d;

  logic                  piso_load;
  logic                  piso_shift;
  logic                  handshake;
  logic                  last_of_chain;
  logic                  last_of_word;

  ccff_word_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk     (prog_clk),
    .rst_n   (prog_reset_n),
    .i_load  (piso_load),
    .i_shift (piso_shift),
    .i_word  (cfg_data),
    .o_msb   (ccff_head)
  );

  assign last_of_chain = (bit_cnt_q == CNT_W'(1));
  assign last_of_word  = (wbit_q == '0);
  assign handshake     = cfg_valid & cfg_ready;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    wbit_d     = wbit_q;
    error_d    = error_q;
    mis_d      = mis_q;
    cfg_ready  = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    // The head/tail pair on the wire in a shift cycle is bit k in and bit k out.
    if (shift_en_q && (mode_q == MODE_VERIFY) && (ccff_tail != ccff_head)) begin
      error_d = 1'b1;
      if (mis_q != {MISMATCH_W{1'b1}}) begin
        mis_d = mis_q + MISMATCH_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          mode_d    = mode;
          error_d   = 1'b0;
          mis_d     = '0;
          bit_cnt_d = CNT_W'(CHAIN_LEN);
        end
      end

      FETCH: begin
        cfg_ready = 1'b1;
        if (abort) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (cfg_valid) begin
          piso_load = 1'b1;
          wbit_d    = WB_W'(WORD_W - 1);
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        piso_shift = 1'b1;
        bit_cnt_d  = bit_cnt_q - CNT_W'(1);
        wbit_d     = wbit_q - WB_W'(1);
        cfg_ready  = last_of_word & ~last_of_chain;
        if (abort) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (last_of_chain) begin
          state_d = DONE;
        end else if (last_of_word) begin
          if (handshake) begin
            piso_load = 1'b1;
            wbit_d    = WB_W'(WORD_W - 1);
          end else begin
            state_d = FETCH;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    shift_en_d = (state_d == SHIFT);
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_LOAD;
      bit_cnt_q  <= '0;
      wbit_q     <= '0;
      shift_en_q <= 1'b0;
      error_q    <= 1'b0;
      mis_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      bit_cnt_q  <= bit_cnt_d;
      wbit_q     <= wbit_d;
      shift_en_q <= shift_en_d;
      error_q    <= error_d;
      mis_q      <= mis_d;
    end
  end

  assign ccff_shift_en = shift_en_q;
  assign busy          = (state_q == FETCH) || (state_q == SHIFT);
  assign done          = (state_q == DONE);
  assign error         = error_q;
  assign mismatch_cnt  = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ccff_chain_loader                                                       |
// | Table of passes against a bit-level chain model; plus reset corner cases.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ccff_chain_loader;

  localparam int CL = 40;
  localparam int WW = 32;

  logic          prog_clk;
  logic          prog_reset_n;
  logic          start;
  logic          mode;
  logic          abort;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   mismatch_cnt;

  ccff_chain_loader #(
    .CHAIN_LEN (CL),
    .WORD_W    (WW)
  ) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start),
    .mode          (mode),
    .abort         (abort),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .mismatch_cnt  (mismatch_cnt)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Fabric chain: holds its contents across loader resets.
  logic [CL-1:0] chain = '0;
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1];

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  int shift_cnt = 0, done_cnt = 0, done_cyc = 0;
  int first_base = 0, first_shift_cyc = 0, last_shift_cyc = 0;
  always @(negedge prog_clk) begin
    if (ccff_shift_en) begin
      shift_cnt      <= shift_cnt + 1;
      last_shift_cyc <= cyc;
      if (shift_cnt == first_base) first_shift_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  typedef struct {
    logic          md;
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    int            stall;
    int            abort_at;
    int            poke_at;
    int            exp_shifts;
    int            exp_done;
    int            exp_lat;
    int            exp_gap;
    logic          exp_err;
    int            exp_mis;
    logic [CL-1:0] exp_chain;
  } vec_t;

  vec_t          tbl[$];
  logic [CL-1:0] mdl;
  int            vectors = 0;
  int            miscompares = 0;
  int            abort_tgt = 0, poke_tgt = 0;
  bit            aborted = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
  endtask

  // Chain after n shifts of the MSB-first stream {w0, w1}.
  function automatic logic [CL-1:0] model_shift(input logic [CL-1:0] prev,
                                               input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                                               input int n);
    logic [2*WW-1:0] s;
    logic [CL-1:0]   c;
    s = {w0, w1};
    c = prev;
    for (int k = 0; k < n; k++) c = {c[CL-2:0], s[2*WW-1-k]};
    return c;
  endfunction

  task automatic add_row(input logic md, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                         input int stall, input int abort_at, input int poke_at);
    vec_t            v;
    int              n;
    logic [2*WW-1:0] s;
    s           = {w0, w1};
    n           = (abort_at > 0) ? abort_at : CL;
    v.md        = md;
    v.w0        = w0;
    v.w1        = w1;
    v.stall     = stall;
    v.abort_at  = abort_at;
    v.poke_at   = poke_at;
    v.exp_shifts = n;
    v.exp_done  = (abort_at > 0) ? 0 : 1;
    v.exp_lat   = 2 + CL + stall;
    v.exp_gap   = stall;
    v.exp_mis   = 0;
    if (md) for (int k = 0; k < n; k++) if (mdl[CL-1-k] != s[2*WW-1-k]) v.exp_mis++;
    v.exp_err   = (abort_at > 0) || (v.exp_mis > 0);
    v.exp_chain = model_shift(mdl, w0, w1, n);
    mdl         = v.exp_chain;
    tbl.push_back(v);
  endtask

  task automatic tick();
    bit was;
    was = abort;
    @(negedge prog_clk);
    #1;
    if (was) begin
      chk("abort_busy_next", busy, 0);
      chk("abort_shen_next", ccff_shift_en, 0);
      aborted = 1;
    end
    abort = (abort_tgt > 0) && ccff_shift_en && (shift_cnt == abort_tgt);
    if (abort) abort_tgt = 0;
    start = (poke_tgt > 0) && ccff_shift_en && (shift_cnt == poke_tgt);
    if (start) begin
      mode     = ~mode;
      poke_tgt = 0;
    end
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int stall);
    int s;
    int n;
    s = stall;
    n = 0;
    cfg_valid = 1'b0;
    while (s > 0 && !aborted && n < 200) begin
      if (cfg_ready) s--;
      tick();
      n++;
    end
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (!cfg_ready && !aborted && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) timeout("send_word");
    if (!aborted) tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run_pass(input vec_t v);
    int s0, d0, n0, n, shifts;
    s0         = shift_cnt;
    d0         = done_cnt;
    first_base = s0;
    aborted    = 0;
    abort_tgt  = (v.abort_at > 0) ? s0 + v.abort_at : 0;
    poke_tgt   = (v.poke_at > 0) ? s0 + v.poke_at : 0;
    mode       = v.md;
    start      = 1'b1;
    n0         = cyc;
    tick();
    chk("ready_latency", cfg_ready, 1);
    send_word(v.w0, 0);
    send_word(v.w1, v.stall);
    n = 0;
    while (done_cnt == d0 && !aborted && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) timeout("wait_done");
    shifts = shift_cnt - s0;
    chk("shift_pulses", shifts, v.exp_shifts);
    chk("done_pulses", done_cnt - d0, v.exp_done);
    chk("first_shift_lat", first_shift_cyc - n0, 2);
    if (v.exp_done != 0) begin
      chk("done_latency", done_cyc - n0, v.exp_lat);
      chk("shift_gap", (last_shift_cyc - first_shift_cyc + 1) - shifts, v.exp_gap);
    end
    chk("busy_end", busy, 0);
    chk("error", error, v.exp_err);
    chk("mismatch_cnt", mismatch_cnt, v.exp_mis);
    chk("chain", chain, v.exp_chain);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] w0, w1, f0, f1;
    int            st;
    vec_t          fin;

    prog_reset_n = 1'b0;
    start        = 1'b0;
    mode         = 1'b0;
    abort        = 1'b0;
    cfg_data     = '0;
    cfg_valid    = 1'b0;

    mdl = '0;
    add_row(1'b0, 32'hA5A5_F00D, 32'hC300_0000, 0, 0, 0);
    add_row(1'b1, 32'hA5A5_F00D, 32'hC300_0000, 0, 0, 0);
    add_row(1'b1, 32'hA5A5_F00C, 32'hC300_0000, 0, 0, 0);
    add_row(1'b0, 32'hA5A5_F00D, 32'hC300_0000, 5, 0, 0);
    add_row(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 10, 0);
    add_row(1'b0, 32'hA5A5_F00D, 32'hC300_0000, 0, 0, 5);
    add_row(1'b1, 32'hA5A5_F00C, 32'hC300_0000, 0, 0, 7);
    add_row(1'b0, 32'hA5A5_F00D, 32'hC3FF_FFFF, 0, 0, 0);
    add_row(1'b1, 32'hA5A5_F00D, 32'hC300_0000, 1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      w0 = $urandom;
      w1 = $urandom;
      f0 = $urandom & $urandom & $urandom;
      f1 = $urandom & $urandom;
      st = $urandom_range(0, 3);
      add_row(1'b0, w0, w1, st, 0, 0);
      add_row(1'b1, w0 ^ f0, w1 ^ f1, $urandom_range(0, 3), 0, 0);
    end

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shen", ccff_shift_en, 0);
    chk("rst_error", error, 0);
    chk("rst_mis", mismatch_cnt, 0);
    tick();
    tick();
    prog_reset_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) run_pass(tbl[i]);

    // VERIFY against the inverted chain so error/mismatch are live when reset hits.
    mode  = 1'b1;
    start = 1'b1;
    tick();
    chk("mid_ready", cfg_ready, 1);
    cfg_data  = ~mdl[CL-1:CL-WW];
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    chk("mid_shen", ccff_shift_en, 1);
    chk("mid_error", error, 1);
    chk("mid_mis", mismatch_cnt, 3);
    #2 prog_reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", cfg_ready, 0);
    chk("arst_head", ccff_head, 0);
    chk("arst_shen", ccff_shift_en, 0);
    chk("arst_error", error, 0);
    chk("arst_mis", mismatch_cnt, 0);
    tick();
    prog_reset_n = 1'b1;
    tick();

    add_row(1'b0, 32'h0F0F_3C3C, 32'h5A00_0000, 0, 0, 0);
    fin = tbl[tbl.size()-1];
    run_pass(fin);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
